// File: rtl/eth_status_counters.sv
// Per-event MAC status counters with an atomic snapshot into shadow registers.
// Software reads only the shadow copy; snap_req freezes and clears the live set in one edge.

module eth_stat_lane #(
    parameter int CW        = 32,
    parameter bit SATURATE  = 1'b1,
    parameter bit EDGE_MODE = 1'b0
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          run_i,
    input  logic          ev_i,
    input  logic          snap_i,
    output logic [CW-1:0] shadow_o,
    output logic          snap_ovf_o
);
    logic [CW-1:0] live_q, live_d, nxt, shadow_q, shadow_d;
    logic          ovf_q, ovf_d, sovf_q, sovf_d, prev_q, prev_d;
    logic          inc, at_max, ovf_now;

    always_comb begin
        prev_d  = run_i ? ev_i : prev_q;
        inc     = run_i & ev_i & (EDGE_MODE ? ~prev_q : 1'b1);
        at_max  = (live_q == {CW{1'b1}});
        ovf_now = inc & at_max;
        nxt     = live_q;
        if (inc) nxt = at_max ? (SATURATE ? live_q : '0) : live_q + {{(CW-1){1'b0}}, 1'b1};
        // The snap-cycle increment lands in the snapshot, never in the new period.
        if (run_i && snap_i) begin
            shadow_d = nxt;
            sovf_d   = ovf_q | ovf_now;
            live_d   = '0;
            ovf_d    = 1'b0;
        end else begin
            shadow_d = shadow_q;
            sovf_d   = sovf_q;
            live_d   = nxt;
            ovf_d    = ovf_q | ovf_now;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            live_q   <= '0;
            shadow_q <= '0;
            ovf_q    <= 1'b0;
            sovf_q   <= 1'b0;
            prev_q   <= 1'b0;
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            sovf_q   <= sovf_d;
            prev_q   <= prev_d;
        end
    end

    assign shadow_o   = shadow_q;
    assign snap_ovf_o = sovf_q;
endmodule

module eth_status_counters #(
    parameter int EVENT_COUNT   = 9,
    parameter int COUNTER_WIDTH = 32,
    parameter bit SATURATE      = 1'b1,
    parameter bit EDGE_MODE     = 1'b0,
    parameter int AW            = 4
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic [EVENT_COUNT-1:0]   event_in,
    input  logic                     snap_req,
    input  logic                     rd_req,
    input  logic [AW-1:0]            rd_addr,
    output logic                     rd_ack,
    output logic [COUNTER_WIDTH-1:0] rd_data,
    output logic [EVENT_COUNT-1:0]   snap_overflow,
    output logic [15:0]              snap_count
);
    logic [1:0]  rst_sync_q;
    logic        run;
    logic [15:0] snap_count_q, snap_count_d;
    logic        rd_ack_q, rd_ack_d;
    logic [COUNTER_WIDTH-1:0] rd_data_q, rd_data_d, rd_mux;
    logic [EVENT_COUNT-1:0][COUNTER_WIDTH-1:0] shadow;

    // Release is retimed by two flops; the block stays idle until run rises.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run = rst_sync_q[1];

    for (genvar g = 0; g < EVENT_COUNT; g++) begin : g_lane
        eth_stat_lane #(
            .CW(COUNTER_WIDTH), .SATURATE(SATURATE), .EDGE_MODE(EDGE_MODE)
        ) u_lane (
            .clock(clock), .resetn(resetn), .run_i(run), .ev_i(event_in[g]),
            .snap_i(snap_req), .shadow_o(shadow[g]), .snap_ovf_o(snap_overflow[g])
        );
    end

    // Addresses past the last lane match nothing and read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < EVENT_COUNT; i++)
            if (rd_addr == AW'(i)) rd_mux = shadow[i];
        rd_ack_d     = run & rd_req;
        rd_data_d    = rd_ack_d ? rd_mux : rd_data_q;
        snap_count_d = (run & snap_req) ? snap_count_q + 16'd1 : snap_count_q;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            snap_count_q <= '0;
            rd_ack_q     <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            snap_count_q <= snap_count_d;
            rd_ack_q     <= rd_ack_d;
            rd_data_q    <= rd_data_d;
        end
    end

    assign rd_ack     = rd_ack_q;
    assign rd_data    = rd_data_q;
    assign snap_count = snap_count_q;
endmodule

// File: tb/tb_eth_status_counters.sv
// Bench for eth_status_counters: three configurations share one stimulus stream,
// checked against a reference model scoreboard plus hand-derived constants.

module tb_eth_status_counters;
    localparam int N  = 9;
    localparam int AW = 4;

    logic clock = 1'b0;
    logic resetn;
    logic [N-1:0] event_in;
    logic snap_req, rd_req;
    logic [AW-1:0] rd_addr;
    logic [2:0] ack;
    logic [31:0] d0;
    logic [3:0] d1, d2;
    logic [N-1:0] so [3];
    logic [15:0] sc [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    eth_status_counters #(.EVENT_COUNT(N), .COUNTER_WIDTH(32), .SATURATE(1'b1), .EDGE_MODE(1'b0), .AW(AW)) u_dut0 (
        .clock(clock), .resetn(resetn), .event_in(event_in), .snap_req(snap_req), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_ack(ack[0]), .rd_data(d0), .snap_overflow(so[0]), .snap_count(sc[0]));
    eth_status_counters #(.EVENT_COUNT(N), .COUNTER_WIDTH(4), .SATURATE(1'b1), .EDGE_MODE(1'b1), .AW(AW)) u_dut1 (
        .clock(clock), .resetn(resetn), .event_in(event_in), .snap_req(snap_req), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_ack(ack[1]), .rd_data(d1), .snap_overflow(so[1]), .snap_count(sc[1]));
    eth_status_counters #(.EVENT_COUNT(N), .COUNTER_WIDTH(4), .SATURATE(1'b0), .EDGE_MODE(1'b0), .AW(AW)) u_dut2 (
        .clock(clock), .resetn(resetn), .event_in(event_in), .snap_req(snap_req), .rd_req(rd_req),
        .rd_addr(rd_addr), .rd_ack(ack[2]), .rd_data(d2), .snap_overflow(so[2]), .snap_count(sc[2]));

    // Reference model, one slot per configuration.
    int cw  [3] = '{32, 4, 4};
    bit sat [3] = '{1'b1, 1'b1, 1'b0};
    bit edg [3] = '{1'b0, 1'b1, 1'b0};
    longint m_live [3][N];
    longint m_shad [3][N];
    bit     m_ovf  [3][N];
    bit     m_sovf [3][N];
    bit     m_prev [3][N];
    int     m_sc   [3];
    longint m_rd   [3];

    typedef struct {
        bit           ack;
        longint       d   [3];
        logic [N-1:0] sovf [3];
        int           sc  [3];
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [N-1:0]  ev;
        bit            snap;
        bit            rd;
        logic [AW-1:0] addr;
        bit            chk;
        logic [31:0]   exp;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [63:0] dout(int k);
        return (k == 0) ? {32'd0, d0} : (k == 1) ? {60'd0, d1} : {60'd0, d2};
    endfunction

    task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                m_live[k][i] = 0; m_shad[k][i] = 0;
                m_ovf[k][i] = 0; m_sovf[k][i] = 0; m_prev[k][i] = 0;
            end
            m_sc[k] = 0; m_rd[k] = 0;
        end
        sb.delete();
    endtask

    task automatic model_step(logic [N-1:0] ev, bit sn, bit rd, logic [AW-1:0] a);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            longint mx = (longint'(1) << cw[k]) - 1;
            if (rd) m_rd[k] = (int'(a) < N) ? m_shad[k][a] : 0;
            for (int i = 0; i < N; i++) begin
                bit inc = edg[k] ? (ev[i] && !m_prev[k][i]) : ev[i];
                bit ov = 1'b0;
                longint nxt = m_live[k][i];
                m_prev[k][i] = ev[i];
                if (inc) begin
                    if (nxt == mx) begin ov = 1'b1; nxt = sat[k] ? mx : 0; end
                    else nxt = nxt + 1;
                end
                if (sn) begin
                    m_shad[k][i] = nxt; m_sovf[k][i] = m_ovf[k][i] | ov;
                    m_live[k][i] = 0;   m_ovf[k][i] = 1'b0;
                end else begin
                    m_live[k][i] = nxt; m_ovf[k][i] = m_ovf[k][i] | ov;
                end
                e.sovf[k][i] = m_sovf[k][i];
            end
            if (sn) m_sc[k] = (m_sc[k] + 1) & 16'hffff;
            e.d[k]  = m_rd[k];
            e.sc[k] = m_sc[k];
        end
        e.ack = rd;
        sb.push_back(e);
    endtask

    task automatic check_sb();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty @%0t", $time);
            return;
        end
        e = sb.pop_front();
        for (int k = 0; k < 3; k++) begin
            cmp($sformatf("rd_ack[%0d]", k), {63'd0, ack[k]}, {63'd0, e.ack});
            cmp($sformatf("rd_data[%0d]", k), dout(k), e.d[k]);
            cmp($sformatf("snap_overflow[%0d]", k), {55'd0, so[k]}, {55'd0, e.sovf[k]});
            cmp($sformatf("snap_count[%0d]", k), {48'd0, sc[k]}, 64'(e.sc[k]));
        end
    endtask

    task automatic step(logic [N-1:0] ev, bit sn, bit rd, logic [AW-1:0] a);
        @(negedge clock);
        event_in = ev; snap_req = sn; rd_req = rd; rd_addr = a;
        model_step(ev, sn, rd, a);
        @(posedge clock);
        #1;
        check_sb();
    endtask

    task automatic check_all_zero(string tag);
        for (int k = 0; k < 3; k++) begin
            cmp({tag, $sformatf("_ack%0d", k)}, {63'd0, ack[k]}, 64'd0);
            cmp({tag, $sformatf("_data%0d", k)}, dout(k), 64'd0);
            cmp({tag, $sformatf("_ovf%0d", k)}, {55'd0, so[k]}, 64'd0);
            cmp({tag, $sformatf("_cnt%0d", k)}, {48'd0, sc[k]}, 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout @%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        event_in = '0; snap_req = 1'b0; rd_req = 1'b0; rd_addr = '0;
        resetn = 1'b1;
        model_reset();
        #2 resetn = 1'b0;
        #2 check_all_zero("reset");
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        repeat (3) step('0, 0, 0, 0);

        // Level counting on lane 2, snapshot, then sweep every address incl. out-of-range.
        for (int c = 0; c < 5; c++) tbl.push_back('{9'h004, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0});
        tbl.push_back('{9'h000, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0});
        for (int a = 0; a < 10; a++)
            tbl.push_back('{9'h000, 1'b0, 1'b1, AW'(a), 1'b1, (a == 2) ? 32'd5 : 32'd0});
        for (int v = 0; v < tbl.size(); v++) begin
            step(tbl[v].ev, tbl[v].snap, tbl[v].rd, tbl[v].addr);
            if (tbl[v].chk) begin
                cmp($sformatf("tbl%0d_ack", v), {63'd0, ack[0]}, 64'd1);
                cmp($sformatf("tbl%0d_data", v), dout(0), {32'd0, tbl[v].exp});
            end
        end

        // Edge mode on lane 0: 1,0,1,1,1,0,1 -> three rising edges.
        begin
            bit pat [7] = '{1, 0, 1, 1, 1, 0, 1};
            for (int c = 0; c < 7; c++) step({8'd0, pat[c]}, 0, 0, 0);
        end
        step('0, 1, 0, 0);
        step('0, 0, 1, 0);
        cmp("edge_count", dout(1), 64'd3);
        cmp("level_count", dout(0), 64'd5);

        // 20 events on lane 1 into 4-bit counters: saturate vs wrap.
        for (int c = 0; c < 20; c++) begin step(9'h002, 0, 0, 0); step('0, 0, 0, 0); end
        step('0, 1, 0, 0);
        step('0, 0, 1, 1);
        cmp("sat_data", dout(1), 64'd15);
        cmp("sat_ovf", {63'd0, so[1][1]}, 64'd1);
        cmp("wrap20_data", dout(2), 64'd4);
        step('0, 1, 0, 0);
        step('0, 0, 1, 1);
        cmp("sat_clear_data", dout(1), 64'd0);
        cmp("sat_clear_ovf", {63'd0, so[1][1]}, 64'd0);

        // 17 events: wrap config reads 1 with overflow flagged.
        for (int c = 0; c < 17; c++) begin step(9'h002, 0, 0, 0); step('0, 0, 0, 0); end
        step('0, 1, 0, 0);
        step('0, 0, 1, 1);
        cmp("wrap_data", dout(2), 64'd1);
        cmp("wrap_ovf", {63'd0, so[2][1]}, 64'd1);
        cmp("wrap_level_data", dout(0), 64'd17);

        // Event coincident with snap lands in the snapshot; same-cycle read sees old shadow.
        step(9'h008, 0, 0, 0);
        step('0, 1, 0, 0);
        step(9'h008, 0, 0, 0);
        step('0, 0, 0, 0);
        step(9'h008, 0, 0, 0);
        step('0, 0, 0, 0);
        step(9'h008, 1, 1, 3);
        cmp("snap_rd_old", dout(0), 64'd1);
        step('0, 0, 1, 3);
        cmp("snap_coincident", dout(0), 64'd3);
        cmp("snap_coincident_edge", dout(1), 64'd3);
        step('0, 1, 0, 0);
        step('0, 0, 1, 3);
        cmp("new_period_zero", dout(0), 64'd0);
        step('0, 0, 0, 0);
        cmp("data_hold", dout(0), 64'd0);

        // Random traffic, including back-to-back reads.
        for (int c = 0; c < 150; c++)
            step(N'($urandom), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1,
                 AW'($urandom_range(0, 15)));

        // Asynchronous reset mid-read.
        step(9'h1ff, 0, 1, 0);
        step(9'h1ff, 1, 1, 0);
        step(9'h1ff, 0, 1, 0);
        #2 resetn = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        event_in = '0; snap_req = 1'b0; rd_req = 1'b0;
        @(negedge clock);
        #2 resetn = 1'b1;
        repeat (3) step('0, 0, 0, 0);
        step('0, 0, 1, AW'(N));
        cmp("oob_ack", {63'd0, ack[0]}, 64'd1);
        cmp("oob_data", dout(0), 64'd0);
        step(9'h004, 1, 0, 0);
        cmp("snap_count_restart", {48'd0, sc[0]}, 64'd1);
        step('0, 0, 1, 2);
        cmp("post_reset_data", dout(0), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/eth_status_counters.md
ETH_STATUS_COUNTERS -- requirements
Module: eth_status_counters

Interface
REQ-001 Parameter EVENT_COUNT, default 9: number of event inputs, legal range 1..32.
REQ-002 Parameter COUNTER_WIDTH, default 32: width of each counter, legal range 4..48.
REQ-003 Parameter SATURATE, default 1: 1 = counters saturate at all-ones; 0 = counters wrap to zero.
REQ-004 Parameter EDGE_MODE, default 0: 0 = count every cycle the event is high; 1 = count rising edges only.
REQ-005 Parameter AW, default 4: read address width; SHALL satisfy 2^AW >= EVENT_COUNT.
REQ-006 clock  input  1  sole clock; every register in the block is clocked on its rising edge.
REQ-007 resetn  input  1  asynchronous, active-low reset.
REQ-008 event_in  input  EVENT_COUNT  status pulses, synchronous to clock (for example MAC FIFO/error indications).
REQ-009 snap_req  input  1  single-cycle request to snapshot and clear the live counters.
REQ-010 rd_req  input  1  read strobe.
REQ-011 rd_addr  input  AW  counter index to read.
REQ-012 rd_ack  output  1  read response valid.
REQ-013 rd_data  output  COUNTER_WIDTH  read response data.
REQ-014 snap_overflow  output  EVENT_COUNT  overflow flags captured by the last snapshot.
REQ-015 snap_count  output  16  number of snapshots taken; wraps at 65535.

Function
REQ-016 Each event i SHALL have a live counter live[i], a shadow counter shadow[i], a sticky live overflow flag ovf[i] and a shadow flag snap_overflow[i].
REQ-017 Increment condition: event_in[i]=1 when EDGE_MODE=0; event_in[i]=1 and the previous-cycle sample=0 when EDGE_MODE=1. The previous-cycle sample register SHALL reset to 0.
REQ-018 On increment with live[i] below all-ones: live[i] SHALL take live[i]+1 at the next edge.
REQ-019 On increment with live[i] at all-ones: SATURATE=1 holds the value; SATURATE=0 wraps it to 0. Both cases set ovf[i]=1.
REQ-020 On snap_req=1: shadow[i] SHALL take the live value plus that cycle's increment, with saturate/wrap applied. In the same edge snap_overflow[i] SHALL take ovf[i] OR that cycle's overflow, live[i] SHALL clear to 0, ovf[i] SHALL clear to 0, and snap_count SHALL increment. Every index SHALL be updated atomically in that one edge.
REQ-021 An event coincident with snap_req SHALL be counted in the snapshot, not in the new period.
REQ-022 A read SHALL complete in one cycle: rd_req=1 at edge N gives rd_ack=1 and rd_data=shadow[rd_addr] after edge N. rd_ack SHALL be 0 after any edge where rd_req=0.
REQ-023 Back-to-back reads on consecutive cycles SHALL be supported; there is no backpressure.
REQ-024 A read with rd_addr >= EVENT_COUNT SHALL return rd_data=0 with rd_ack=1.
REQ-025 A read coincident with snap_req SHALL return the pre-snapshot shadow value.
REQ-026 rd_data SHALL hold its last value while rd_ack=0.
REQ-027 Live counters SHALL never be directly readable; reads SHALL return shadow values only.

Reset
REQ-028 While resetn=0, the following SHALL all be 0, asynchronously and regardless of clock: live, shadow, ovf, snap_overflow, snap_count, rd_ack, rd_data and the edge-detect registers.
REQ-029 Reset deassertion SHALL be synchronised internally. The first increment SHALL occur no earlier than the second rising edge after deassertion.
REQ-030 Reset asserted mid-count or mid-read SHALL discard all state; no partial snapshot SHALL survive.

Verification
REQ-031 EDGE_MODE=0: event_in[2] high for 5 cycles, then snap_req, then read addr 2 -> rd_ack after 1 cycle, rd_data=5; all other indices read 0.
REQ-032 EDGE_MODE=1: event_in[0] toggling 1,0,1,1,1,0,1, then snap, read 0 -> rd_data=3.
REQ-033 COUNTER_WIDTH=4, SATURATE=1: 20 events on index 1, then snap -> rd_data=15 and snap_overflow[1]=1. Second snap with no events -> rd_data=0 and snap_overflow[1]=0.
REQ-034 COUNTER_WIDTH=4, SATURATE=0: 17 events, then snap -> rd_data=1 and snap_overflow=1.
REQ-035 Event on index 3 in the same cycle as snap_req, after 2 earlier events -> snapshot reads 3 and the next period starts at 0. A read issued in the same cycle as that snap returns the previous shadow.
REQ-036 resetn pulsed low asynchronously mid-sequence -> all outputs read 0 immediately; rd_addr=EVENT_COUNT returns 0 with ack; snap_count restarts from 0.
